// File: rtl/ifb_pkg.sv
// Shared types and widths for the instruction prefetch buffer.
package ifb_pkg;

   localparam int WORD_ADDR_W = 12;
   localparam int INSTR_W     = 32;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifb_entry_t;

endpackage

// File: rtl/ifb_fifo.sv
// Small circular FIFO of {pc, instr} entries with synchronous clear.
module ifb_fifo
   import ifb_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = ifb_entry_t
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    clear,
   input  entry_t                  wr_data,
   output entry_t                  rd_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int PW = $clog2(DEPTH);

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            do_pop;

   assign do_pop = pop & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !do_pop)
            count <= count + 1'b1;
         else if (!push && do_pop)
            count <= count - 1'b1;
      end
   end

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push && !clear)
         mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/instr_prefetch_buf.sv
// Sequential instruction prefetcher with branch flush; optional same-cycle
// response forwarding enabled by defining IFB_BYPASS_EN.
module instr_prefetch_buf
   import ifb_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   fetch_en_i,
   input  logic                   branch_i,
   input  logic [31:0]            branch_addr_i,
   output logic                   mem_req_o,
   output logic [WORD_ADDR_W-1:0] mem_addr_o,
   input  logic [INSTR_W-1:0]     mem_rdata_i,
   input  logic                   mem_rvalid_i,
   output logic                   instr_valid_o,
   input  logic                   instr_ready_i,
   output logic [INSTR_W-1:0]     instr_o,
   output logic [31:0]            instr_pc_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]  fetch_pc;
   logic [31:0]  req_pc;
   logic [31:0]  issue_addr;
   logic         inflight;
   logic         resp;
   logic         bypass;
   logic         push;
   logic         pop;
   logic [CW-1:0] count;
   logic [CW:0]  occupancy;
   logic         full;
   logic         empty;
   ifb_entry_t   head;
   ifb_entry_t   hold;
   ifb_entry_t   wr_entry;
   ifb_entry_t   shown;

   // A branch discards the response and any pop of the same cycle.
   assign resp = mem_rvalid_i & inflight & ~branch_i;
   assign pop  = ~empty & instr_ready_i & ~branch_i;

`ifdef IFB_BYPASS_EN
   assign bypass = resp & empty;
`else
   assign bypass = 1'b0;
`endif

   assign push      = resp & ~(bypass & instr_ready_i);
   assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
   assign mem_req_o = ~rst_i & ((fetch_en_i & (occupancy < (CW+1)'(DEPTH))) | branch_i);

   assign issue_addr = branch_i ? (branch_addr_i & ~32'h3) : fetch_pc;
   assign mem_addr_o = issue_addr[13:2];
   assign wr_entry   = '{pc: req_pc, instr: mem_rdata_i};

   ifb_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (ifb_entry_t)
   ) u_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .push    (push),
      .pop     (pop),
      .clear   (branch_i),
      .wr_data (wr_entry),
      .rd_data (head),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_pc <= BOOT_ADDR;
         req_pc   <= BOOT_ADDR;
         inflight <= 1'b0;
      end else begin
         inflight <= mem_req_o;
         if (mem_req_o) begin
            req_pc   <= issue_addr;
            fetch_pc <= issue_addr + 32'd4;
         end
      end
   end

   // Outputs keep the last presented word whenever nothing is valid.
   assign instr_valid_o = ~empty | bypass;
   assign shown         = !empty ? head : (bypass ? wr_entry : hold);
   assign instr_o       = shown.instr;
   assign instr_pc_o    = shown.pc;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         hold <= '0;
      else if (instr_valid_o)
         hold <= shown;
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(push && full && !pop));

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Randomized and directed bench for instr_prefetch_buf with a queue-level model.
module tb_instr_prefetch_buf;

   localparam int          DEPTH = 4;
   localparam logic [31:0] BOOT  = 32'h0000_0000;
`ifdef IFB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_en = 1'b0;
   logic        branch = 1'b0;
   logic [31:0] baddr = '0;
   logic        rdy = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   wire         mem_req;
   wire [11:0]  mem_addr;
   wire         valid;
   wire [31:0]  instr;
   wire [31:0]  ipc;

   instr_prefetch_buf #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .fetch_en_i    (fetch_en),
      .branch_i      (branch),
      .branch_addr_i (baddr),
      .mem_req_o     (mem_req),
      .mem_addr_o    (mem_addr),
      .mem_rdata_i   (mem_rdata),
      .mem_rvalid_i  (mem_rvalid),
      .instr_valid_o (valid),
      .instr_ready_i (rdy),
      .instr_o       (instr),
      .instr_pc_o    (ipc)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model state: buffered words, next fetch pc, outstanding request.
   ent_t        q[$];
   logic [31:0] m_pc = BOOT;
   logic [31:0] m_req_pc = BOOT;
   bit          m_infl = 1'b0;
   ent_t        m_last = '0;

   bit          e_pop, e_byp, e_req, e_valid;
   ent_t        e_out;
   logic [31:0] e_iss;
   bit          s_req = 1'b0;
   logic [11:0] s_addr = '0;

   function automatic logic [31:0] memfn(input logic [11:0] w);
      return 32'hC0DE_0000 ^ {8'h00, w, 12'h000} ^ {20'h0, ~w};
   endfunction

   function automatic ent_t mk(input logic [31:0] pc);
      ent_t e;
      e.pc    = pc;
      e.instr = memfn(pc[13:2]);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit r, input bit en, input bit br, input logic [31:0] ba, input bit rd);
      @(negedge clk);
      rst = r; fetch_en = en; branch = br; baddr = ba; rdy = rd;
      #1;
      if (r) begin
         q.delete();
         m_infl = 1'b0; m_pc = BOOT; m_req_pc = BOOT; m_last = '0;
      end
      e_pop = !r && q.size() > 0 && rd && !br;
`ifdef IFB_BYPASS_EN
      e_byp = !r && q.size() == 0 && m_infl && !br;
`else
      e_byp = 1'b0;
`endif
      e_valid = (q.size() > 0) || e_byp;
      e_out   = (q.size() > 0) ? q[0] : (e_byp ? mk(m_req_pc) : m_last);
      e_req   = !r && ((en && (q.size() + int'(m_infl) - int'(e_pop)) < DEPTH) || br);
      e_iss   = br ? {ba[31:2], 2'b00} : m_pc;
      check("valid", valid, e_valid);
      check("instr", instr, e_out.instr);
      check("instr_pc", ipc, e_out.pc);
      check("mem_req", mem_req, e_req);
      check("mem_addr", mem_addr, e_iss[13:2]);
      s_req  = mem_req;
      s_addr = mem_addr;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      if (!rst) begin
         if (e_valid) m_last = e_out;
         if (branch) q.delete();
         else begin
            if (e_pop) void'(q.pop_front());
            if (m_infl && !(e_byp && rdy)) q.push_back(mk(m_req_pc));
         end
         if (e_req) begin
            m_req_pc = e_iss;
            m_pc     = e_iss + 32'd4;
         end
         m_infl = e_req;
      end
      mem_rvalid = s_req;
      mem_rdata  = memfn(s_addr);
   endtask

   task automatic cyc(input bit r, input bit en, input bit br, input logic [31:0] ba, input bit rd);
      drive(r, en, br, ba, rd);
      advance();
   endtask

   // Cycle after a branch (already issued), then bounded wait for the target word.
   task automatic expect_target(input logic [31:0] t);
      bit found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0, 32'h0, 1);
         if (i == 0 && LAT == 2) check("post_branch_valid", valid, 0);
         if (!found && valid) begin
            check("target_pc", ipc, t);
            found = 1'b1;
         end
         advance();
      end
      if (!found) check("target_timeout", 0, 1);
   endtask

   initial begin
      logic [31:0] nxt;
      logic [31:0] wrap_pcs [3];
      int          widx;

      // Reset release, streaming from BOOT
      cyc(1, 1, 0, 0, 1);
      cyc(1, 1, 0, 0, 1);
      for (int k = 0; k < 8; k++) begin
         drive(0, 1, 0, 32'h0, 1);
         if (k < 3) check("t1_addr", mem_addr, k);
         if (k == LAT - 1) check("t1_first_valid_early", valid, 0);
         if (k >= LAT && k < LAT + 3) begin
            check("t1_valid", valid, 1);
            check("t1_pc", ipc, 32'(k - LAT) * 4);
         end
         advance();
      end
      nxt = 32'(8 - LAT) * 4;

      // Stall: buffer fills to DEPTH and requests stop
      for (int k = 0; k < 10; k++) begin
         drive(0, 1, 0, 32'h0, 0);
         if (k == 9) begin
            check("stall_req_off", mem_req, 0);
            check("stall_valid", valid, 1);
            check("stall_head_pc", ipc, nxt);
         end
         advance();
      end
      for (int k = 0; k < 8; k++) begin
         drive(0, 1, 0, 32'h0, 1);
         check("release_valid", valid, 1);
         check("release_pc", ipc, nxt);
         nxt = nxt + 32'd4;
         advance();
      end

      // Branch with 3 buffered words and one inflight
      cyc(1, 1, 0, 0, 0);
      for (int k = 0; k < 4; k++) cyc(0, 1, 0, 32'h0, 0);
      drive(0, 1, 1, 32'h0000_0100, 0);
      check("br_req", mem_req, 1);
      check("br_addr", mem_addr, 32'h040);
      advance();
      expect_target(32'h0000_0100);

      // Branch coinciding with a pop and an arriving response
      for (int k = 0; k < 6; k++) cyc(0, 1, 0, 32'h0, 1);
      drive(0, 1, 1, 32'h0000_0200, 1);
      check("br2_addr", mem_addr, 32'h080);
      advance();
      expect_target(32'h0000_0200);

      // Reset mid-stream with a full buffer
      for (int k = 0; k < 8; k++) cyc(0, 1, 0, 32'h0, 0);
      drive(1, 1, 0, 32'h0, 0);
      check("rst_valid", valid, 0);
      check("rst_req", mem_req, 0);
      check("rst_pc", ipc, 0);
      check("rst_instr", instr, 0);
      advance();
      cyc(1, 1, 0, 32'h0, 0);
      for (int k = 0; k <= LAT; k++) begin
         drive(0, 1, 0, 32'h0, 1);
         if (k == 0) begin
            check("restart_req", mem_req, 1);
            check("restart_addr", mem_addr, BOOT[13:2]);
         end
         if (k == LAT) check("restart_pc", ipc, BOOT);
         advance();
      end

      // Fetch pc wrap at the top of the address space
      wrap_pcs[0] = 32'hFFFF_FFF8;
      wrap_pcs[1] = 32'hFFFF_FFFC;
      wrap_pcs[2] = 32'h0000_0000;
      widx = 0;
      drive(0, 1, 1, 32'hFFFF_FFF8, 1);
      check("wrap_addr0", mem_addr, 32'hFFE);
      advance();
      for (int k = 0; k < 6; k++) begin
         drive(0, 1, 0, 32'h0, 1);
         if (k == 0) check("wrap_addr1", mem_addr, 32'hFFF);
         if (k == 1) check("wrap_addr2", mem_addr, 32'h000);
         if (valid && widx < 3) begin
            check("wrap_pc", ipc, wrap_pcs[widx]);
            widx++;
         end
         advance();
      end
      check("wrap_count", widx, 3);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         bit          r  = ($urandom_range(0, 399) == 0);
         bit          en = ($urandom_range(0, 99) < 85);
         bit          br = ($urandom_range(0, 19) == 0);
         bit          rd = ($urandom_range(0, 99) < 60);
         logic [31:0] ba = $urandom();
         if ($urandom_range(0, 7) == 0) ba = 32'hFFFF_FFF0 | (ba & 32'hF);
         cyc(r, en, br, ba, rd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_prefetch_buf.md
# instr_prefetch_buf

Sequential instruction prefetcher that sits directly upstream of the instruction memory. It issues word reads, captures the registered read data, and buffers fetched words in a small FIFO. It presents them to the core decode stage over a valid/ready handshake, and flushes and redirects on branches. The block owns the memory read port only; the top level ties the memory `we`, `wmask` and `wdata` to zero.

## Interface
- `DEPTH`, 4 — FIFO entries; power of two, ≥ 2.
- `BOOT_ADDR`, 32'h0000_0000 — byte PC loaded at reset; word-aligned.

- `clk_i` in 1 — clock.
- `rst_i` in 1 — reset, asynchronous, active-high.
- `fetch_en_i` in 1 — permits new memory requests; buffered data still drains when low.
- `branch_i` in 1 — redirect strobe, single cycle.
- `branch_addr_i` in 32 — target byte address; bits [1:0] ignored.
- `mem_req_o` in→out 1 — read request to instruction memory.
- `mem_addr_o` out 12 — word address = `fetch_pc[13:2]`.
- `mem_rdata_i` in 32 — read data, meaningful when `mem_rvalid_i` = 1.
- `mem_rvalid_i` in 1 — response strobe, exactly one cycle after an accepted `mem_req_o`.
- `instr_valid_o` out 1 — head word available.
- `instr_ready_i` in 1 — core consumes head when both valid and ready are high.
- `instr_o` out 32 — head instruction.
- `instr_pc_o` out 32 — byte PC of head instruction.

## Operation
- State:
  - `fetch_pc` is the next address to request.
  - `inflight` is a 1-bit flag: a request was issued last cycle.
  - The FIFO stores {pc, instr} pairs.
  - `count` ranges 0..DEPTH.
- Issue rule:
  - `mem_req_o` = `fetch_en_i` & ((`count` + `inflight` − pop) < DEPTH) | `branch_i`.
  - A branch always issues, regardless of `fetch_en_i`.
- Address selection:
  - `mem_addr_o` = `branch_i` ? `branch_addr_i[13:2]` : `fetch_pc[13:2]`.
  - On issue, `fetch_pc` ← issued address + 4, wrapping modulo 2^32.
- Response handling:
  - When `mem_rvalid_i` = 1 and no branch occurs this cycle, push {pc of that request, `mem_rdata_i`}.
  - The pc of the request is tracked in a `req_pc` register.
- Branch handling, when `branch_i` = 1:
  - The FIFO is cleared (`count` ← 0, pointers reset).
  - A response arriving that same cycle is discarded.
  - Any pop that cycle is ignored.
  - The new request is issued to the target.
- Push and pop in the same cycle are allowed; `count` is unchanged.
- Overflow is impossible by the issue rule. A push when full is an assertion failure.
- Pop when empty has no effect.
- The block has no state machine beyond the `inflight` and `count` bookkeeping. Modes are implicit: IDLE (`count` = 0, no inflight), STREAM, and FULL (no issue).

## Timing
- Reset values:
  - `mem_req_o` = 0 and `instr_valid_o` = 0.
  - `instr_o` = 0 and `instr_pc_o` = 0.
  - `fetch_pc` = `BOOT_ADDR`, `inflight` = 0, `count` = 0.
- Reset is asynchronous. Assertion mid-operation drops all buffered and inflight words immediately. The first `mem_req_o` is asserted in the first cycle after deassertion if `fetch_en_i` = 1.
- `mem_req_o` and `mem_addr_o` are combinational from registered state and `branch_i`.
- Latency without bypass:
  - Cycle N: request issued.
  - Cycle N+1: `mem_rvalid_i` high; push.
  - Cycle N+2: `instr_valid_o` high.
- Throughput is one instruction per cycle in steady state with `instr_ready_i` held high.
- Branch at cycle B:
  - `instr_valid_o` = 0 in cycle B+1.
  - The target instruction is valid in cycle B+2, or B+1 with bypass.
- `instr_o` and `instr_pc_o` hold their last value while `instr_valid_o` = 0.

## Configuration
- `IFB_BYPASS_EN` defined:
  - When `count` = 0, `mem_rvalid_i` = 1 and `branch_i` = 0, the response is forwarded combinationally to `instr_o`/`instr_pc_o`, with `instr_valid_o` = 1 in the same cycle.
  - If `instr_ready_i` = 1, the word is not pushed. Otherwise it is pushed.
  - First-instruction latency becomes 1 cycle after request.
- `IFB_BYPASS_EN` undefined: outputs are driven from FIFO head registers only, and latency is 2 cycles.

## Structure
- Package `ifb_pkg`:
  - `typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ifb_entry_t;`
  - `localparam` `WORD_ADDR_W` = 12.
  - `localparam` `INSTR_W` = 32.
- Sub-module `ifb_fifo`:
  - Parameterised on DEPTH and `ifb_entry_t`.
  - Provides push/pop/clear, count, full and empty.
- The top holds issue logic, `fetch_pc`, `req_pc`, `inflight` and bypass.

## Test plan
- Reset release with `fetch_en_i` = 1, `instr_ready_i` = 1 → requests at word addrs 0,1,2,… on consecutive cycles. `instr_pc_o` = 0x0, 0x4, 0x8 in order; first valid at cycle 2 (cycle 1 with `IFB_BYPASS_EN`).
- `instr_ready_i` = 0 for 10 cycles → exactly DEPTH = 4 words buffered and `mem_req_o` stops. Release yields 4 back-to-back instructions, then streaming resumes without gaps or duplicates.
- Branch to 0x0000_0100 while the FIFO holds 3 words and one is inflight → all old words are dropped, `mem_addr_o` = 0x040 in the branch cycle, and the next `instr_pc_o` is 0x100.
- Branch in the same cycle as a pop and an arriving response → neither the popped nor the arriving word is seen again, and `count` = 0 the next cycle.
- `rst_i` asserted mid-stream with the FIFO full → `instr_valid_o` = 0 and `mem_req_o` = 0 immediately. After release, fetch restarts at `BOOT_ADDR`.
- `fetch_pc` = 0xFFFF_FFFC → the next request is word addr 0x000 and `instr_pc_o` wraps to 0x0.
